// File: rtl/core_pkg.sv
// Shared core definitions: writeback select codes, load funct3 codes and
// the writeback stage state type.
package core_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMMIT    = 2'd1,
    WAIT_LOAD = 2'd2
  } wb_state_t;

endpackage

// File: rtl/load_align.sv
// Picks the byte/halfword addressed by off out of a word-aligned load word
// and sign- or zero-extends it according to funct3.
module load_align
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // A misaligned halfword ignores off[0] and uses only off[1].
  always_comb begin
    byteSel = word[{off, 3'b000} +: 8];
    halfSel = word[{off[1], 4'b0000} +: 16];
    case (funct3)
      LOAD_LB:  data = {{(XLEN-8){byteSel[7]}}, byteSel};
      LOAD_LBU: data = {{(XLEN-8){1'b0}}, byteSel};
      LOAD_LH:  data = {{(XLEN-16){halfSel[15]}}, halfSel};
      LOAD_LHU: data = {{(XLEN-16){1'b0}}, halfSel};
      LOAD_LW:  data = word;
      default:  data = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: takes retiring instructions from MEM, waits for load data,
// drives the RegFile write port (never x0), a forwarding tap and instret.
module wb_stage
  import core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic [1:0]       mem_wb_sel,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_pc_plus4,
  input  logic [2:0]       mem_funct3,
  input  logic             dcache_rsp_valid,
  input  logic [XLEN-1:0]  dcache_rsp_data,
  output logic             reg_write_en,
  output logic [4:0]       reg_write_dest_addr,
  output logic [XLEN-1:0]  reg_write_data,
  output logic             wb_fwd_valid,
  output logic [4:0]       wb_fwd_rd,
  output logic [XLEN-1:0]  wb_fwd_data,
  output logic [CNT_W-1:0] instret
);

  wb_state_t        state_q, state_d;
  logic             regWrite_q, regWrite_d;
  logic [4:0]       rd_q, rd_d;
  logic [1:0]       wbSel_q, wbSel_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       off_q, off_d;
  logic [XLEN-1:0]  value_q, value_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [XLEN-1:0]  alignedData;
  logic             accept;

  load_align #(.XLEN(XLEN)) u_load_align (
    .funct3 (funct3_q),
    .off    (off_q),
    .word   (dcache_rsp_data),
    .data   (alignedData)
  );

  assign mem_ready = !reset && (state_q != WAIT_LOAD);
  assign accept    = mem_valid && mem_ready;

  // A new accept in COMMIT overrides the fall-back to IDLE, giving full-rate commits.
  always_comb begin
    state_d    = state_q;
    regWrite_d = regWrite_q;
    rd_d       = rd_q;
    wbSel_d    = wbSel_q;
    funct3_d   = funct3_q;
    off_d      = off_q;
    value_d    = value_q;
    instret_d  = instret_q;

    case (state_q)
      IDLE: ;
      COMMIT: begin
        instret_d = instret_q + 1'b1;
        state_d   = IDLE;
      end
      WAIT_LOAD: begin
        if (dcache_rsp_valid && wbSel_q == WB_SEL_LOAD) begin
          value_d = alignedData;
          state_d = COMMIT;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      regWrite_d = mem_reg_write;
      rd_d       = mem_rd;
      wbSel_d    = mem_wb_sel;
      funct3_d   = mem_funct3;
      off_d      = mem_alu_result[1:0];
      value_d    = (mem_wb_sel == WB_SEL_PC4) ? mem_pc_plus4 : mem_alu_result;
      state_d    = (mem_wb_sel == WB_SEL_LOAD) ? WAIT_LOAD : COMMIT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      regWrite_q <= 1'b0;
      rd_q       <= 5'd0;
      wbSel_q    <= WB_SEL_ALU;
      funct3_q   <= 3'd0;
      off_q      <= 2'd0;
      value_q    <= '0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      regWrite_q <= regWrite_d;
      rd_q       <= rd_d;
      wbSel_q    <= wbSel_d;
      funct3_q   <= funct3_d;
      off_q      <= off_d;
      value_q    <= value_d;
      instret_q  <= instret_d;
    end
  end

  assign reg_write_en        = !reset && (state_q == COMMIT) && regWrite_q && (rd_q != 5'd0);
  assign reg_write_dest_addr = rd_q;
  assign reg_write_data      = value_q;
  assign wb_fwd_valid        = reg_write_en;
  assign wb_fwd_rd           = rd_q;
  assign wb_fwd_data         = value_q;
  assign instret             = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, hand-written
// multi-cycle sequences and randomized instructions against a reference model.
module tb_wb_stage;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [2:0]  f3;
    logic [31:0] rsp;
    int          delay;
    logic        expEn;
    logic [31:0] expData;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_pc_plus4;
  logic [2:0]  mem_funct3;
  logic        dcache_rsp_valid;
  logic [31:0] dcache_rsp_data;
  logic        reg_write_en;
  logic [4:0]  reg_write_dest_addr;
  logic [31:0] reg_write_data;
  logic        wb_fwd_valid;
  logic [4:0]  wb_fwd_rd;
  logic [31:0] wb_fwd_data;
  logic [31:0] instret;

  int total = 0;
  int bad = 0;
  int writeCount = 0;
  int expInstret = 0;
  logic [31:0] shadowRf [32];
  vec_t vecs [11];

  wb_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk                 (clk),
    .reset               (reset),
    .mem_valid           (mem_valid),
    .mem_ready           (mem_ready),
    .mem_reg_write       (mem_reg_write),
    .mem_rd              (mem_rd),
    .mem_wb_sel          (mem_wb_sel),
    .mem_alu_result      (mem_alu_result),
    .mem_pc_plus4        (mem_pc_plus4),
    .mem_funct3          (mem_funct3),
    .dcache_rsp_valid    (dcache_rsp_valid),
    .dcache_rsp_data     (dcache_rsp_data),
    .reg_write_en        (reg_write_en),
    .reg_write_dest_addr (reg_write_dest_addr),
    .reg_write_data      (reg_write_data),
    .wb_fwd_valid        (wb_fwd_valid),
    .wb_fwd_rd           (wb_fwd_rd),
    .wb_fwd_data         (wb_fwd_data),
    .instret             (instret)
  );

  always #5 clk = ~clk;

  // Stand-in RegFile: records what the write port actually commits.
  always @(posedge clk) begin
    if (reg_write_en) begin
      shadowRf[reg_write_dest_addr] <= reg_write_data;
      writeCount <= writeCount + 1;
    end
  end

  function automatic vec_t makeVec(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                                   input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3,
                                   input logic [31:0] rsp, input int delay, input logic expEn,
                                   input logic [31:0] expData);
    vec_t v;
    v.rw = rw; v.rd = rd; v.sel = sel; v.alu = alu; v.pc4 = pc4; v.f3 = f3;
    v.rsp = rsp; v.delay = delay; v.expEn = expEn; v.expData = expData;
    return v;
  endfunction

  // Load result from the ISA rules: shift the addressed lane down, mask, extend.
  function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] word);
    logic [31:0] b;
    logic [31:0] h;
    b = (word >> (8 * int'(off))) & 32'hFF;
    h = (word >> (16 * (int'(off) / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic sendInstr(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                           input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3);
    int guard;
    guard = 0;
    while (mem_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("ready_timeout", {31'd0, mem_ready}, 32'd1);
    mem_valid = 1'b1; mem_reg_write = rw; mem_rd = rd; mem_wb_sel = sel;
    mem_alu_result = alu; mem_pc_plus4 = pc4; mem_funct3 = f3;
    @(negedge clk);
    mem_valid = 1'b0;
  endtask

  // Issues one instruction and, for loads, delivers the response; ends in the commit cycle.
  task automatic applyStimulus(input vec_t v);
    sendInstr(v.rw, v.rd, v.sel, v.alu, v.pc4, v.f3);
    if (v.sel == 2'b01) begin
      checkOutput("ready_wait", {31'd0, mem_ready}, 32'd0);
      repeat (v.delay) @(negedge clk);
      checkOutput("noen_wait", {31'd0, reg_write_en}, 32'd0);
      dcache_rsp_valid = 1'b1;
      dcache_rsp_data = v.rsp;
      @(negedge clk);
      dcache_rsp_valid = 1'b0;
      dcache_rsp_data = $urandom;
    end
  endtask

  task automatic runVector(input vec_t v, input string name);
    int wcBefore;
    wcBefore = writeCount;
    applyStimulus(v);
    checkOutput({name, "_en"}, {31'd0, reg_write_en}, {31'd0, v.expEn});
    checkOutput({name, "_fwdv"}, {31'd0, wb_fwd_valid}, {31'd0, v.expEn});
    if (v.expEn) begin
      checkOutput({name, "_dest"}, {27'd0, reg_write_dest_addr}, {27'd0, v.rd});
      checkOutput({name, "_data"}, reg_write_data, v.expData);
      checkOutput({name, "_fwdd"}, wb_fwd_data, v.expData);
    end
    @(negedge clk);
    expInstret++;
    checkOutput({name, "_instret"}, instret, expInstret);
    checkOutput({name, "_wcount"}, writeCount, wcBefore + (v.expEn ? 1 : 0));
    if (v.expEn) checkOutput({name, "_rf"}, shadowRf[v.rd], v.expData);
  endtask

  initial begin
    reset = 1'b1; mem_valid = 1'b0; mem_reg_write = 1'b0; mem_rd = 5'd0; mem_wb_sel = 2'b00;
    mem_alu_result = 32'd0; mem_pc_plus4 = 32'd0; mem_funct3 = 3'd0;
    dcache_rsp_valid = 1'b0; dcache_rsp_data = 32'd0;
    for (int i = 0; i < 32; i++) shadowRf[i] = 32'd0;

    vecs[0]  = makeVec(1'b1, 5'd5,  2'b00, 32'd124,      32'd0,     3'd0, 32'd0,          0, 1'b1, 32'd124);
    vecs[1]  = makeVec(1'b1, 5'd0,  2'b00, 32'h0000_DEAD, 32'd0,    3'd0, 32'd0,          0, 1'b0, 32'd0);
    vecs[2]  = makeVec(1'b1, 5'd6,  2'b01, 32'h0000_1003, 32'd0,    3'd0, 32'h80FF_1234,  3, 1'b1, 32'hFFFF_FF80);
    vecs[3]  = makeVec(1'b1, 5'd7,  2'b01, 32'h0000_1003, 32'd0,    3'd4, 32'h80FF_1234,  3, 1'b1, 32'h0000_0080);
    vecs[4]  = makeVec(1'b1, 5'd8,  2'b01, 32'h0000_1002, 32'd0,    3'd1, 32'h80FF_1234,  3, 1'b1, 32'hFFFF_80FF);
    vecs[5]  = makeVec(1'b1, 5'd9,  2'b01, 32'h0000_1000, 32'd0,    3'd5, 32'h80FF_1234,  3, 1'b1, 32'h0000_1234);
    vecs[6]  = makeVec(1'b1, 5'd1,  2'b10, 32'h0000_0999, 32'h104,  3'd0, 32'd0,          0, 1'b1, 32'h0000_0104);
    vecs[7]  = makeVec(1'b0, 5'd3,  2'b00, 32'h0000_0033, 32'd0,    3'd0, 32'd0,          0, 1'b0, 32'd0);
    vecs[8]  = makeVec(1'b1, 5'd11, 2'b01, 32'h0000_2001, 32'd0,    3'd2, 32'h80FF_1234,  1, 1'b1, 32'h80FF_1234);
    vecs[9]  = makeVec(1'b1, 5'd0,  2'b01, 32'h0000_2000, 32'd0,    3'd2, 32'h1111_2222,  2, 1'b0, 32'd0);
    vecs[10] = makeVec(1'b1, 5'd12, 2'b11, 32'h0000_0055, 32'h200,  3'd0, 32'd0,          0, 1'b1, 32'h0000_0055);

    repeat (2) @(negedge clk);
    checkOutput("rst_ready", {31'd0, mem_ready}, 32'd0);
    checkOutput("rst_en", {31'd0, reg_write_en}, 32'd0);
    checkOutput("rst_fwdv", {31'd0, wb_fwd_valid}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_ready", {31'd0, mem_ready}, 32'd1);
    checkOutput("post_en", {31'd0, reg_write_en}, 32'd0);
    checkOutput("post_dest", {27'd0, reg_write_dest_addr}, 32'd0);
    checkOutput("post_data", reg_write_data, 32'd0);
    checkOutput("post_instret", instret, 32'd0);

    for (int i = 0; i < 11; i++) runVector(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back commits with mem_valid held high.
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd10; mem_wb_sel = 2'b00; mem_alu_result = 32'd214;
    @(negedge clk);
    mem_rd = 5'd14; mem_alu_result = 32'd7;
    checkOutput("b2b_en1", {31'd0, reg_write_en}, 32'd1);
    checkOutput("b2b_dest1", {27'd0, reg_write_dest_addr}, 32'd10);
    checkOutput("b2b_data1", reg_write_data, 32'd214);
    checkOutput("b2b_ready", {31'd0, mem_ready}, 32'd1);
    @(negedge clk);
    mem_valid = 1'b0;
    checkOutput("b2b_en2", {31'd0, reg_write_en}, 32'd1);
    checkOutput("b2b_dest2", {27'd0, reg_write_dest_addr}, 32'd14);
    checkOutput("b2b_data2", reg_write_data, 32'd7);
    @(negedge clk);
    expInstret += 2;
    checkOutput("b2b_x10", shadowRf[10], 32'd214);
    checkOutput("b2b_x14", shadowRf[14], 32'd7);
    checkOutput("b2b_instret", instret, expInstret);
    checkOutput("b2b_idle_en", {31'd0, reg_write_en}, 32'd0);

    // Reset while waiting for a load, then a late response and a stray response.
    begin
      int wc;
      wc = writeCount;
      sendInstr(1'b1, 5'd13, 2'b01, 32'h0000_3000, 32'd0, 3'd2);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("wrst_ready", {31'd0, mem_ready}, 32'd0);
      checkOutput("wrst_en", {31'd0, reg_write_en}, 32'd0);
      reset = 1'b0;
      dcache_rsp_valid = 1'b1; dcache_rsp_data = 32'hCAFE_F00D;
      @(negedge clk);
      dcache_rsp_valid = 1'b0;
      @(negedge clk);
      expInstret = 0;
      checkOutput("wrst_nowrite", writeCount, wc);
      checkOutput("wrst_idle", {31'd0, mem_ready}, 32'd1);
      checkOutput("wrst_instret", instret, 32'd0);
      checkOutput("wrst_data", reg_write_data, 32'd0);
      dcache_rsp_valid = 1'b1; dcache_rsp_data = 32'h1234_5678;
      @(negedge clk);
      dcache_rsp_valid = 1'b0;
      checkOutput("stray_en", {31'd0, reg_write_en}, 32'd0);
      @(negedge clk);
      checkOutput("stray_ready", {31'd0, mem_ready}, 32'd1);
      checkOutput("stray_nowrite", writeCount, wc);
      checkOutput("stray_instret", instret, 32'd0);
      runVector(makeVec(1'b1, 5'd2, 2'b00, 32'h77, 32'd0, 3'd0, 32'd0, 0, 1'b1, 32'h77), "after_rst");
    end

    // Randomized instructions against the reference model.
    for (int n = 0; n < 60; n++) begin
      vec_t v;
      v.rw = 1'($urandom_range(0, 1));
      v.rd = 5'($urandom_range(0, 31));
      v.sel = 2'($urandom_range(0, 3));
      v.alu = $urandom;
      v.pc4 = $urandom;
      v.f3 = 3'($urandom_range(0, 7));
      v.rsp = $urandom;
      v.delay = $urandom_range(0, 3);
      v.expEn = v.rw && (v.rd != 5'd0);
      case (v.sel)
        2'b01:   v.expData = refLoad(v.f3, v.alu[1:0], v.rsp);
        2'b10:   v.expData = v.pc4;
        default: v.expData = v.alu;
      endcase
      runVector(v, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
